// File: rtl/reg_file_onehot.sv
// reg_file_onehot: 32 x XLEN integer register file with a one-hot write select,
// two combinational read ports, x0 hardwired to zero, optional write-through
// bypass, and a sticky flag raised by a write request with a malformed select.
module reg_file_onehot #(
  parameter int unsigned XLEN   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [31:0]     wr_sel,
  input  logic [XLEN-1:0] wr_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            sel_err
);

  // True when exactly one bit of the select is set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  logic [XLEN-1:0] regs_q [0:31];
  logic [XLEN-1:0] regs_d [0:31];
  logic            sel_err_q;
  logic            sel_err_d;
  logic            sel_ok_s;
  logic            wr_legal_s;
  logic            fwd_ok_s;

  assign sel_ok_s   = is_onehot(wr_sel);
  // A legal write targets x1..x31 with a clean one-hot select.
  assign wr_legal_s = wr_en & sel_ok_s & ~wr_sel[0];
  // Nothing is forwarded while reset holds the file at zero.
  assign fwd_ok_s   = BYPASS & wr_legal_s & rst_n;

  // Next state: load the selected register on a legal write, latch select errors.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_legal_s) begin
      for (int i = 1; i < 32; i++) begin
        if (wr_sel[i]) begin
          regs_d[i] = wr_data;
        end else begin
          regs_d[i] = regs_q[i];
        end
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_d[i] = regs_q[i];
      end
    end
    regs_d[0] = '0;
    if (wr_en && !sel_ok_s) begin
      sel_err_d = 1'b1;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      sel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      sel_err_q <= sel_err_d;
    end
  end

  // Read port 1: x0 is zero, otherwise forwarded write data or stored value.
  always_comb begin
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (fwd_ok_s && wr_sel[rs1_addr]) begin
      rs1_data = wr_data;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (fwd_ok_s && wr_sel[rs2_addr]) begin
      rs2_data = wr_data;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_reg_file_onehot.sv
// tb_reg_file_onehot: directed bench driving a bypass and a non-bypass instance
// in parallel from the same inputs; expected values go through a scoreboard queue.
module tb_reg_file_onehot;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            clk_run;
  logic            rst_n;
  logic            wr_en;
  logic [31:0]     wr_sel;
  logic [XLEN-1:0] wr_data;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] b_rs1, b_rs2, n_rs1, n_rs2;
  logic            b_err, n_err;

  reg_file_onehot #(.XLEN(XLEN), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1), .rs2_data(b_rs2), .sel_err(b_err)
  );

  reg_file_onehot #(.XLEN(XLEN), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1), .rs2_data(n_rs2), .sel_err(n_err)
  );

  // Free-running clock that can be held to test asynchronous reset.
  always #5 if (clk_run) clk = ~clk;

  // Observation points: 0/1 bypass rs1/rs2, 2/3 no-bypass rs1/rs2, 4/5 sel_err.
  typedef struct {
    string       tag;
    int unsigned src;
    logic [31:0] exp;
  } sb_t;

  sb_t q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  function automatic logic [31:0] observe(input int unsigned src);
    case (src)
      0: return b_rs1;
      1: return b_rs2;
      2: return n_rs1;
      3: return n_rs2;
      4: return {31'd0, b_err};
      5: return {31'd0, n_err};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int unsigned src, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.src = src; e.exp = exp;
    q.push_back(e);
  endtask

  // Same expectation on both read ports of both instances.
  task automatic push_rd_all(input string tag, input logic [31:0] e1, input logic [31:0] e2);
    push(tag, 0, e1); push(tag, 1, e2); push(tag, 2, e1); push(tag, 3, e2);
  endtask

  task automatic push_err(input string tag, input logic e);
    push(tag, 4, {31'd0, e}); push(tag, 5, {31'd0, e});
  endtask

  task automatic check_sb();
    sb_t e;
    logic [31:0] obs;
    #1;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.src);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s src=%0d observed=%h expected=%h", e.tag, e.src, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic en, input logic [31:0] sel, input logic [31:0] data);
    wr_en = en; wr_sel = sel; wr_data = data;
  endtask

  initial begin
    clk = 1'b0; clk_run = 1'b1; rst_n = 1'b0;
    drive_wr(1'b0, 32'd0, 32'd0);
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #12 rst_n = 1'b1;

    // Preload x5 with all ones, then reset with the clock held.
    rs1_addr = 5'd5;
    drive_wr(1'b1, 32'd1 << 5, 32'hFFFF_FFFF);
    push("pre_x5_byp", 0, 32'hFFFF_FFFF);
    push("pre_x5_nob", 2, 32'h0000_0000);
    check_sb();
    step();
    drive_wr(1'b0, 32'd0, 32'd0);
    push_rd_all("x5_loaded", 32'hFFFF_FFFF, 32'h0000_0000);
    check_sb();
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      push_rd_all("reset_read", 32'd0, 32'd0);
      check_sb();
    end
    push_err("reset_err", 1'b0);
    check_sb();
    rst_n = 1'b1;
    clk_run = 1'b1;
    step();

    // Full sweep of all 32 one-hot selects.
    for (int i = 0; i < 32; i++) begin
      drive_wr(1'b1, 32'd1 << i, 32'hA5A5_0000 + 32'(i));
      step();
    end
    drive_wr(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i);
      push_rd_all("sweep", (i == 0) ? 32'd0 : 32'hA5A5_0000 + 32'(i),
                  (i == 0) ? 32'd0 : 32'hA5A5_0000 + 32'(i));
      check_sb();
    end
    push_err("sweep_err", 1'b0);
    check_sb();

    // Bypass versus registered read of a same-cycle write.
    drive_wr(1'b1, 32'd1 << 7, 32'h0000_0011);
    step();
    rs1_addr = 5'd7; rs2_addr = 5'd6;
    drive_wr(1'b1, 32'd1 << 7, 32'h0000_0022);
    push("byp_before", 0, 32'h0000_0022);
    push("nob_before", 2, 32'h0000_0011);
    push("byp_other", 1, 32'hA5A5_0006);
    push("nob_other", 3, 32'hA5A5_0006);
    check_sb();
    step();
    drive_wr(1'b0, 32'd0, 32'd0);
    push_rd_all("after_edge", 32'h0000_0022, 32'hA5A5_0006);
    check_sb();

    // Back-to-back writes to one register: last edge wins.
    drive_wr(1'b1, 32'd1 << 4, 32'h0000_0001);
    step();
    drive_wr(1'b1, 32'd1 << 4, 32'h0000_0002);
    step();
    drive_wr(1'b0, 32'd0, 32'd0);
    rs1_addr = 5'd4; rs2_addr = 5'd4;
    push_rd_all("b2b", 32'h0000_0002, 32'h0000_0002);
    check_sb();

    // Write to x0 is discarded silently and never forwarded.
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    drive_wr(1'b1, 32'h0000_0001, 32'h0000_0005);
    push_rd_all("x0_before", 32'd0, 32'd0);
    check_sb();
    step();
    drive_wr(1'b0, 32'd0, 32'd0);
    push_rd_all("x0_after", 32'd0, 32'd0);
    push_err("x0_err", 1'b0);
    check_sb();

    // wr_en low with a bad select raises nothing.
    drive_wr(1'b0, 32'h0000_0006, 32'h0000_DEAD);
    step();
    push_err("idle_badsel", 1'b0);
    check_sb();

    // Multi-hot select: no write, not forwarded, sticky error.
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    drive_wr(1'b1, 32'h0000_0006, 32'h0000_DEAD);
    push_rd_all("mh_before", 32'hA5A5_0001, 32'hA5A5_0002);
    check_sb();
    step();
    drive_wr(1'b0, 32'd0, 32'd0);
    push_rd_all("mh_after", 32'hA5A5_0001, 32'hA5A5_0002);
    push_err("mh_err", 1'b1);
    check_sb();
    drive_wr(1'b1, 32'd1 << 9, 32'h0000_0099);
    step();
    drive_wr(1'b0, 32'd0, 32'd0);
    rs1_addr = 5'd9;
    push("legal_after_err_b", 0, 32'h0000_0099);
    push("legal_after_err_n", 2, 32'h0000_0099);
    push_err("err_sticky", 1'b1);
    check_sb();

    // Zero select after a fresh reset.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    push_err("err_cleared", 1'b0);
    check_sb();
    step();
    rs1_addr = 5'd3;
    drive_wr(1'b1, 32'd0, 32'h0000_0077);
    step();
    drive_wr(1'b0, 32'd0, 32'd0);
    push_err("zero_sel_err", 1'b1);
    push("zero_sel_nowr_b", 0, 32'd0);
    push("zero_sel_nowr_n", 2, 32'd0);
    check_sb();

    // Reset mid-operation while a write to x3 is pending.
    drive_wr(1'b1, 32'd1 << 3, 32'h0000_0033);
    step();
    drive_wr(1'b1, 32'd1 << 3, 32'h0000_0044);
    #2 rst_n = 1'b0;
    push("rst_mid_b", 0, 32'd0);
    push("rst_mid_n", 2, 32'd0);
    push_err("rst_mid_err", 1'b0);
    check_sb();
    step();
    push("rst_edge_b", 0, 32'd0);
    push("rst_edge_n", 2, 32'd0);
    check_sb();
    drive_wr(1'b0, 32'd0, 32'd0);
    #2 rst_n = 1'b1;
    step();
    push("post_rst_b", 0, 32'd0);
    push("post_rst_n", 2, 32'd0);
    check_sb();

    // Release mid-cycle with wr_en high: write lands at the next edge.
    #1 rst_n = 1'b0;
    drive_wr(1'b1, 32'd1 << 3, 32'h0000_0044);
    #2 rst_n = 1'b1;
    push("rel_before_b", 0, 32'h0000_0044);
    push("rel_before_n", 2, 32'd0);
    check_sb();
    step();
    drive_wr(1'b0, 32'd0, 32'd0);
    push("rel_after_b", 0, 32'h0000_0044);
    push("rel_after_n", 2, 32'h0000_0044);
    check_sb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
